// File: rtl/operand_fetch_pkg.sv
// Shared widths, register-zero constant and bus record types for the operand fetch slice.
package cpu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NREG       = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t REG_ZERO = '0;

  // One in-flight result that may be forwarded to a source operand.
  typedef struct packed {
    logic  vld;
    addr_t addr;
    data_t dat;
  } fwd_t;

  // Contents of the registered stage presented to EX.
  typedef struct packed {
    data_t src1;
    data_t src2;
    addr_t dest;
    logic  dest_wen;
    logic  is_load;
  } ex_pkt_t;

endpackage

// File: rtl/operand_fetch_if.sv
// ID/reg_file/bypass/WB/EX bundle seen by operand_fetch; slave is the fetch stage, master its environment.
interface operand_fetch_if;
  import cpu_pkg::*;

  logic  id_valid;
  logic  id_ready;
  addr_t id_rs;
  addr_t id_rt;
  logic  id_rs_used;
  logic  id_rt_used;
  addr_t id_dest;
  logic  id_dest_wen;
  logic  id_is_load;

  addr_t raddr1;
  addr_t raddr2;
  data_t rdata1;
  data_t rdata2;

  logic  ex_fwd_valid;
  addr_t ex_fwd_addr;
  data_t ex_fwd_data;
  logic  mem_fwd_valid;
  addr_t mem_fwd_addr;
  data_t mem_fwd_data;

  logic  wb_wen;
  addr_t wb_waddr;
  data_t wb_wdata;
  logic  wb_ld_done;
  addr_t wb_ld_addr;

  logic  flush;

  logic  ex_valid;
  logic  ex_ready;
  data_t ex_src1;
  data_t ex_src2;
  addr_t ex_dest;
  logic  ex_dest_wen;
  logic  ex_is_load;

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dest, id_dest_wen, id_is_load,
    input  rdata1, rdata2,
    input  ex_fwd_valid, ex_fwd_addr, ex_fwd_data, mem_fwd_valid, mem_fwd_addr, mem_fwd_data,
    input  wb_wen, wb_waddr, wb_wdata, wb_ld_done, wb_ld_addr,
    input  flush, ex_ready,
    output id_ready, raddr1, raddr2,
    output ex_valid, ex_src1, ex_src2, ex_dest, ex_dest_wen, ex_is_load
  );

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dest, id_dest_wen, id_is_load,
    output rdata1, rdata2,
    output ex_fwd_valid, ex_fwd_addr, ex_fwd_data, mem_fwd_valid, mem_fwd_addr, mem_fwd_data,
    output wb_wen, wb_waddr, wb_wdata, wb_ld_done, wb_ld_addr,
    output flush, ex_ready,
    input  id_ready, raddr1, raddr2,
    input  ex_valid, ex_src1, ex_src2, ex_dest, ex_dest_wen, ex_is_load
  );

endinterface

// File: rtl/operand_fetch_bypass.sv
// Combinational source-operand resolution: r0 -> 0, else EX > MEM > WB > reg_file.
// Zero latency, no state, no backpressure.
module operand_bypass
  import cpu_pkg::*;
(
  input  addr_t i_r,
  input  data_t i_rdata,
  input  fwd_t  i_ex,
  input  fwd_t  i_mem,
  input  fwd_t  i_wb,
  output data_t o_operand,
  output logic  o_ex_hit,
  output logic  o_mem_hit,
  output logic  o_wb_hit
);

  logic w_nz;

  assign w_nz      = (i_r != REG_ZERO);
  assign o_ex_hit  = w_nz && i_ex.vld  && (i_ex.addr  == i_r);
  assign o_mem_hit = w_nz && i_mem.vld && (i_mem.addr == i_r);
  assign o_wb_hit  = w_nz && i_wb.vld  && (i_wb.addr  == i_r);

  always_comb begin
    o_operand = i_rdata;
    if (!w_nz)          o_operand = '0;
    else if (o_ex_hit)  o_operand = i_ex.dat;
    else if (o_mem_hit) o_operand = i_mem.dat;
    else if (o_wb_hit)  o_operand = i_wb.dat;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: bypass-resolved sources into a one-cycle registered valid/ready stage toward EX,
// stalling ID on outstanding-load hazards; ex_ready only gates id_ready, never the ex_* outputs.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  operand_fetch_if.slave  bus
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;
  logic            r_ex_valid;
  ex_pkt_t         r_ex;

  fwd_t  w_ex_fwd;
  fwd_t  w_mem_fwd;
  fwd_t  w_wb_fwd;
  data_t w_src1;
  data_t w_src2;
  logic  w_rs_ex_hit, w_rs_mem_hit, w_rs_wb_hit;
  logic  w_rt_ex_hit, w_rt_mem_hit, w_rt_wb_hit;
  logic  w_unused_hits;

  logic  w_rs_haz;
  logic  w_rt_haz;
  logic  w_waw;
  logic  w_stall;
  logic  w_id_ready;
  logic  w_accept;
  logic  w_ld_set;

  assign bus.raddr1 = bus.id_rs;
  assign bus.raddr2 = bus.id_rt;

  assign w_ex_fwd  = {bus.ex_fwd_valid,  bus.ex_fwd_addr,  bus.ex_fwd_data};
  assign w_mem_fwd = {bus.mem_fwd_valid, bus.mem_fwd_addr, bus.mem_fwd_data};
  assign w_wb_fwd  = {bus.wb_wen,        bus.wb_waddr,     bus.wb_wdata};

  operand_bypass u_byp_rs (
    .i_r       (bus.id_rs),
    .i_rdata   (bus.rdata1),
    .i_ex      (w_ex_fwd),
    .i_mem     (w_mem_fwd),
    .i_wb      (w_wb_fwd),
    .o_operand (w_src1),
    .o_ex_hit  (w_rs_ex_hit),
    .o_mem_hit (w_rs_mem_hit),
    .o_wb_hit  (w_rs_wb_hit)
  );

  operand_bypass u_byp_rt (
    .i_r       (bus.id_rt),
    .i_rdata   (bus.rdata2),
    .i_ex      (w_ex_fwd),
    .i_mem     (w_mem_fwd),
    .i_wb      (w_wb_fwd),
    .o_operand (w_src2),
    .o_ex_hit  (w_rt_ex_hit),
    .o_mem_hit (w_rt_mem_hit),
    .o_wb_hit  (w_rt_wb_hit)
  );

  assign w_unused_hits = ^{w_rs_ex_hit, w_rs_mem_hit, w_rs_wb_hit,
                           w_rt_ex_hit, w_rt_mem_hit, w_rt_wb_hit};

  // A load retiring this cycle delivers its data through the WB bypass, so it no longer blocks.
  assign w_rs_haz = bus.id_rs_used && (bus.id_rs != REG_ZERO) && r_pending[bus.id_rs] &&
                    !(bus.wb_ld_done && (bus.wb_ld_addr == bus.id_rs));
  assign w_rt_haz = bus.id_rt_used && (bus.id_rt != REG_ZERO) && r_pending[bus.id_rt] &&
                    !(bus.wb_ld_done && (bus.wb_ld_addr == bus.id_rt));
  assign w_waw    = bus.id_dest_wen && bus.id_is_load && (bus.id_dest != REG_ZERO) &&
                    r_pending[bus.id_dest] &&
                    !(bus.wb_ld_done && (bus.wb_ld_addr == bus.id_dest));

  assign w_stall    = bus.id_valid && (w_rs_haz || w_rt_haz || w_waw);
  assign w_id_ready = !w_stall && !bus.flush && (!r_ex_valid || bus.ex_ready);
  assign w_accept   = bus.id_valid && w_id_ready;
  assign w_ld_set   = w_accept && bus.id_dest_wen && bus.id_is_load && (bus.id_dest != REG_ZERO);

  assign bus.id_ready = w_id_ready;

  // Clear first so a new load to the retiring register keeps its bit set.
  always_comb begin
    w_pending_nxt = r_pending;
    if (bus.wb_ld_done) w_pending_nxt[bus.wb_ld_addr] = 1'b0;
    if (w_ld_set)       w_pending_nxt[bus.id_dest]    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= '0;
      r_ex_valid <= 1'b0;
      r_ex       <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (bus.flush) begin
        r_ex_valid <= 1'b0;
      end else if (w_accept) begin
        r_ex_valid <= 1'b1;
        r_ex       <= '{src1: w_src1, src2: w_src2, dest: bus.id_dest,
                        dest_wen: bus.id_dest_wen, is_load: bus.id_is_load};
      end else if (bus.ex_ready) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign bus.ex_valid    = r_ex_valid;
  assign bus.ex_src1     = r_ex.src1;
  assign bus.ex_src2     = r_ex.src2;
  assign bus.ex_dest     = r_ex.dest;
  assign bus.ex_dest_wen = r_ex.dest_wen;
  assign bus.ex_is_load  = r_ex.is_load;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: bypass vector table plus hand sequences for load-use, WAW, back-pressure,
// flush and reset; accepted instructions queue their expected EX record until the stage emits it.
module tb_operand_fetch;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_fetch_if ifc();

  operand_fetch u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  data_t reg_file [NREG];
  assign ifc.rdata1 = reg_file[ifc.raddr1];
  assign ifc.rdata2 = reg_file[ifc.raddr2];

  typedef struct {
    data_t src1;
    data_t src2;
    addr_t dest;
    logic  wen;
    logic  load;
  } exp_t;

  typedef struct {
    addr_t rs;  addr_t rt;
    logic  exv; addr_t exa; data_t exd;
    logic  mev; addr_t mea; data_t med;
    logic  wbv; addr_t wba; data_t wbd;
    data_t e1;  data_t e2;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t cur_exp;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int rs, input int rt,
                              input int exv, input int exa, input int exd,
                              input int mev, input int mea, input int med,
                              input int wbv, input int wba, input int wbd,
                              input int e1, input int e2);
    vec_t v;
    v.rs  = addr_t'(rs);  v.rt  = addr_t'(rt);
    v.exv = exv[0];       v.exa = addr_t'(exa); v.med = data_t'(med);
    v.exd = data_t'(exd);
    v.mev = mev[0];       v.mea = addr_t'(mea);
    v.wbv = wbv[0];       v.wba = addr_t'(wba); v.wbd = data_t'(wbd);
    v.e1  = data_t'(e1);  v.e2  = data_t'(e2);
    return v;
  endfunction

  task automatic idle();
    ifc.id_valid = 1'b0;   ifc.id_rs = '0;        ifc.id_rt = '0;
    ifc.id_rs_used = 1'b0; ifc.id_rt_used = 1'b0;
    ifc.id_dest = '0;      ifc.id_dest_wen = 1'b0; ifc.id_is_load = 1'b0;
    ifc.ex_fwd_valid = 1'b0;  ifc.ex_fwd_addr = '0;  ifc.ex_fwd_data = '0;
    ifc.mem_fwd_valid = 1'b0; ifc.mem_fwd_addr = '0; ifc.mem_fwd_data = '0;
    ifc.wb_wen = 1'b0; ifc.wb_waddr = '0; ifc.wb_wdata = '0;
    ifc.wb_ld_done = 1'b0; ifc.wb_ld_addr = '0;
    ifc.flush = 1'b0;
  endtask

  task automatic drive(input int rs, input int rt, input bit rs_u, input bit rt_u,
                       input int dest, input bit wen, input bit load,
                       input int e1, input int e2);
    ifc.id_valid = 1'b1;
    ifc.id_rs = addr_t'(rs);   ifc.id_rt = addr_t'(rt);
    ifc.id_rs_used = rs_u;     ifc.id_rt_used = rt_u;
    ifc.id_dest = addr_t'(dest);
    ifc.id_dest_wen = wen;     ifc.id_is_load = load;
    cur_exp = '{src1: data_t'(e1), src2: data_t'(e2), dest: addr_t'(dest), wen: wen, load: load};
  endtask

  task automatic set_wb(input bit wen, input bit done, input int addr, input int data);
    ifc.wb_wen = wen;     ifc.wb_waddr = addr_t'(addr); ifc.wb_wdata = data_t'(data);
    ifc.wb_ld_done = done; ifc.wb_ld_addr = addr_t'(addr);
  endtask

  // Samples at the falling edge; exp_rdy < 0 skips the id_ready check.
  task automatic step(input int exp_rdy);
    exp_t e;
    @(negedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (exp_rdy >= 0) chk("id_ready", 32'(ifc.id_ready), 32'(exp_rdy));
      if (ifc.flush && ifc.ex_valid) begin
        if (q.size() == 0) chk("flush_with_empty_queue", 32'(q.size()), 32'd1);
        else void'(q.pop_front());
      end else if (ifc.ex_valid && ifc.ex_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_ex_valid", 32'(ifc.ex_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("ex_src1", ifc.ex_src1, e.src1);
          chk("ex_src2", ifc.ex_src2, e.src2);
          chk("ex_dest", 32'(ifc.ex_dest), 32'(e.dest));
          chk("ex_dest_wen", 32'(ifc.ex_dest_wen), 32'(e.wen));
          chk("ex_is_load", 32'(ifc.ex_is_load), 32'(e.load));
        end
      end
      if (ifc.id_valid && ifc.id_ready) q.push_back(cur_exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_ex_valid", 32'(ifc.ex_valid), 32'd0);
    chk("rst_ex_src1", ifc.ex_src1, 32'd0);
    chk("rst_ex_src2", ifc.ex_src2, 32'd0);
    chk("rst_ex_dest", 32'(ifc.ex_dest), 32'd0);
    chk("rst_ex_dest_wen", 32'(ifc.ex_dest_wen), 32'd0);
    chk("rst_ex_is_load", 32'(ifc.ex_is_load), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREG; i++) reg_file[i] = 32'h100 + i;
    reg_file[0] = 32'hDEAD0000;
    reg_file[3] = 32'h11;
    reg_file[4] = 32'h22;
    reg_file[5] = 32'hDDDD;
    reg_file[6] = 32'h66;
    reg_file[7] = 32'h777;

    //         rs rt  exv exa exd      mev mea med      wbv wba wbd      e1       e2
    vecs.push_back(mk(3, 4, 0, 0, 0,      0, 0, 0,      0, 0, 0,      'h11,    'h22));
    vecs.push_back(mk(5, 4, 1, 5, 'hAAAA, 1, 5, 'hBBBB, 1, 5, 'hCCCC, 'hAAAA,  'h22));
    vecs.push_back(mk(5, 5, 0, 5, 'hAAAA, 1, 5, 'hBBBB, 1, 5, 'hCCCC, 'hBBBB,  'hBBBB));
    vecs.push_back(mk(5, 3, 0, 5, 'hAAAA, 0, 5, 'hBBBB, 1, 5, 'hCCCC, 'hCCCC,  'h11));
    vecs.push_back(mk(0, 5, 1, 0, 'hAAAA, 1, 5, 'hBBBB, 0, 0, 0,      0,       'hBBBB));
    vecs.push_back(mk(4, 3, 1, 4, 1,      1, 3, 2,      0, 0, 0,      1,       2));
    vecs.push_back(mk(6, 7, 0, 7, 'h5,    0, 0, 0,      0, 6, 'hCCCC, 'h66,    'h777));
    vecs.push_back(mk(3, 0, 0, 3, 9,      1, 3, 5,      1, 0, 'hEE,   5,       0));
    vecs.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0,      0,       0));

    rst = 1'b1;
    idle();
    ifc.ex_ready = 1'b1;
    step(-1);
    step(-1);
    rst = 1'b0;
    chk_reset_state();

    // Bypass table, issued back to back.
    foreach (vecs[i]) begin
      drive(vecs[i].rs, vecs[i].rt, 1'b1, 1'b1, i + 1, 1'b1, 1'b0, vecs[i].e1, vecs[i].e2);
      ifc.ex_fwd_valid  = vecs[i].exv; ifc.ex_fwd_addr  = vecs[i].exa; ifc.ex_fwd_data  = vecs[i].exd;
      ifc.mem_fwd_valid = vecs[i].mev; ifc.mem_fwd_addr = vecs[i].mea; ifc.mem_fwd_data = vecs[i].med;
      ifc.wb_wen = vecs[i].wbv; ifc.wb_waddr = vecs[i].wba; ifc.wb_wdata = vecs[i].wbd;
      step(1);
    end
    idle();
    step(-1);

    // Load-use on r7: stall until the load retires, then pick the value off WB.
    drive(0, 0, 1'b0, 1'b0, 7, 1'b1, 1'b1, 0, 0);
    step(1);
    drive(7, 3, 1'b1, 1'b1, 8, 1'b1, 1'b0, 'h1234, 'h11);
    step(0);
    step(0);
    set_wb(1'b1, 1'b1, 7, 'h1234);
    step(1);
    set_wb(1'b0, 1'b0, 0, 0);
    drive(7, 0, 1'b1, 1'b0, 8, 1'b1, 1'b0, 'h777, 0);
    step(1);
    idle();
    step(-1);

    // Back-pressure: the held instruction stays put and ID is blocked.
    drive(3, 4, 1'b1, 1'b1, 2, 1'b1, 1'b0, 'h11, 'h22);
    step(1);
    ifc.ex_ready = 1'b0;
    drive(5, 4, 1'b1, 1'b1, 3, 1'b0, 1'b0, 'hDDDD, 'h22);
    for (int i = 0; i < 3; i++) begin
      step(0);
      chk("bp_ex_valid", 32'(ifc.ex_valid), 32'd1);
      chk("bp_ex_src1", ifc.ex_src1, 32'h11);
      chk("bp_ex_src2", ifc.ex_src2, 32'h22);
      chk("bp_ex_dest", 32'(ifc.ex_dest), 32'd2);
    end
    ifc.ex_ready = 1'b1;
    step(1);
    idle();
    step(-1);

    // WAW on r9, then set-wins when the second load issues as the first retires.
    drive(0, 0, 1'b0, 1'b0, 9, 1'b1, 1'b1, 0, 0);
    step(1);
    drive(3, 4, 1'b1, 1'b1, 9, 1'b1, 1'b1, 'h11, 'h22);
    step(0);
    step(0);
    set_wb(1'b0, 1'b1, 9, 0);
    step(1);
    set_wb(1'b0, 1'b0, 0, 0);
    drive(9, 0, 1'b1, 1'b0, 10, 1'b1, 1'b0, 'h99, 0);
    step(0);
    step(0);
    set_wb(1'b1, 1'b1, 9, 'h99);
    step(1);
    idle();
    step(-1);

    // Flush kills the held instruction and blocks the one on offer.
    drive(4, 3, 1'b1, 1'b1, 11, 1'b1, 1'b0, 'h22, 'h11);
    step(1);
    ifc.ex_ready = 1'b0;
    drive(3, 3, 1'b1, 1'b1, 12, 1'b1, 1'b0, 'h11, 'h11);
    ifc.flush = 1'b1;
    step(0);
    idle();
    chk("flush_ex_valid", 32'(ifc.ex_valid), 32'd0);
    ifc.ex_ready = 1'b1;
    step(-1);
    chk("flush_no_accept", 32'(ifc.ex_valid), 32'd0);

    // Reset mid-flight with r7 pending.
    drive(0, 0, 1'b0, 1'b0, 7, 1'b1, 1'b1, 0, 0);
    step(1);
    idle();
    rst = 1'b1;
    step(-1);
    rst = 1'b0;
    chk_reset_state();
    drive(7, 4, 1'b1, 1'b1, 13, 1'b1, 1'b0, 'h777, 'h22);
    step(1);
    idle();
    step(-1);
    step(-1);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
